// File: rtl/jtag_led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// jtag_led_pwm_pkg
//
// Shared definitions for the JTAG-programmed LED PWM controller:
//   - ch_w()     : channel-select field width, max(1, clog2(num_ch))
//   - dr_len()   : length of the JTAG user data register
//   - duty_lsb() / chan_lsb() / wr_bit() : field offsets inside the data
//                  register (LSB first: duty, chan, then wr at the MSB)
//   - cmd_t      : decoded control fields of a shifted command word
//   - cmd_valid(): true when a command should be committed to a channel
// -----------------------------------------------------------------------------
package jtag_led_pwm_pkg;

    // Upper bound of the channel field: at most 16 channels.
    localparam int MAX_CH_W = 4;

    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int dr_len(input int num_ch, input int pwm_w);
        return 1 + ch_w(num_ch) + pwm_w;
    endfunction

    function automatic int duty_lsb();
        return 0;
    endfunction

    function automatic int chan_lsb(input int pwm_w);
        return duty_lsb() + pwm_w;
    endfunction

    function automatic int wr_bit(input int ch_w_i, input int pwm_w);
        return chan_lsb(pwm_w) + ch_w_i;
    endfunction

    // Control fields of a command word. The duty field is taken straight
    // from the shift register because its width is a module parameter.
    typedef struct packed {
        logic                wr;
        logic [MAX_CH_W-1:0] chan;
    } cmd_t;

    // A command is applied only when it is a write to an existing channel.
    function automatic logic cmd_valid(input cmd_t c, input int num_ch);
        return c.wr && (int'(c.chan) < num_ch);
    endfunction

endpackage

// File: rtl/jtag_led_pwm_ch.sv
// -----------------------------------------------------------------------------
// jtag_led_pwm_ch
//
// One LED channel: a pending duty written from JTAG, an active duty that is
// only refreshed at the start of a PWM period, the duty compare and the pin
// polarity.
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   wr_en         : write wr_duty into the pending duty this clk
//   wr_duty       : duty value to write
//   cnt           : shared free-running PWM counter
//   cnt_wrap      : high in the clk where cnt is 0 (period start)
//   pend_o        : pending duty (only with JTAG_LED_PWM_READBACK_EN, used
//                   for the readback word)
//   led_o         : registered LED pin
//
// Build option: JTAG_LED_PWM_READBACK_EN adds the pend_o port.
// -----------------------------------------------------------------------------
module jtag_led_pwm_ch
    import jtag_led_pwm_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PWM_W-1:0] wr_duty,
    input  logic [PWM_W-1:0] cnt,
    input  logic             cnt_wrap,
`ifdef JTAG_LED_PWM_READBACK_EN
    output logic [PWM_W-1:0] pend_o,
`endif
    output logic             led_o
);

    logic [PWM_W-1:0] pend_d, pend_q;
    logic [PWM_W-1:0] act_d,  act_q;
    logic             led_d,  led_q;
    logic             lit;

    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        lit    = 1'b0;

        if (wr_en) begin
            pend_d = wr_duty;
        end

        // The active duty only moves at the period start, so a period is
        // never cut short or stretched by a write. A write landing in the
        // same clk is seen at the following wrap.
        if (cnt_wrap) begin
            act_d = pend_q;
        end

        // All-ones is treated as fully on; otherwise cnt < act would leave
        // one dark clk per period.
        if (act_q == '1) begin
            lit = 1'b1;
        end else begin
            lit = (cnt < act_q);
        end

        led_d = lit ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            led_q  <= led_d;
        end
    end

`ifdef JTAG_LED_PWM_READBACK_EN
    assign pend_o = pend_q;
`endif
    assign led_o = led_q;

endmodule

// File: rtl/jtag_led_pwm.sv
// -----------------------------------------------------------------------------
// jtag_led_pwm
//
// Multi-channel LED PWM controller programmed through a BSCANE2 user data
// register. The JTAG signals are oversampled in the clk domain (clk must be
// at least 4x TCK), so everything here runs on clk.
//
// Data register, shifted LSB first: duty[PWM_W-1:0], chan[CH_W-1:0], wr.
// On UPDATE a word with wr=1 and chan < NUM_CH sets that channel's duty.
//
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   jtag_tck/sel/capture/shift/update/tdi : BSCANE2 outputs
//   jtag_tdo       : to BSCANE2 TDO, registered copy of the shift register LSB
//   led[NUM_CH]    : LED pins, polarity set by ACTIVE_LOW
//
// Build option: JTAG_LED_PWM_READBACK_EN makes CAPTURE load
// {0, last written channel, its pending duty} so TDO reads status back.
// Without it, CAPTURE does nothing and TDO returns the previous frame.
// -----------------------------------------------------------------------------
module jtag_led_pwm
    import jtag_led_pwm_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PWM_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_tck,
    input  logic              jtag_sel,
    input  logic              jtag_capture,
    input  logic              jtag_shift,
    input  logic              jtag_update,
    input  logic              jtag_tdi,
    output logic              jtag_tdo,
    output logic [NUM_CH-1:0] led
);

    localparam int CH_W     = ch_w(NUM_CH);
    localparam int DR_LEN   = dr_len(NUM_CH, PWM_W);
    localparam int DUTY_LSB = duty_lsb();
    localparam int CHAN_LSB = chan_lsb(PWM_W);
    localparam int WR_BIT   = wr_bit(CH_W, PWM_W);

    // Positions of the JTAG inputs in the synchroniser bank.
    localparam int J_TCK   = 0;
    localparam int J_SEL   = 1;
    localparam int J_CAP   = 2;
    localparam int J_SHIFT = 3;
    localparam int J_UPD   = 4;
    localparam int J_TDI   = 5;
    localparam int NJ      = 6;

    // -------------------------------------------------------------------------
    // Synchronisers. Each input gets SYNC_STAGES flops plus one extra delay
    // flop. The edge pulses are built from the last sync stage against the
    // delay flop and registered, so when a pulse is high the delay flops
    // hold exactly the sample that produced it: sel/shift/tdi line up with
    // the TCK edge without any further alignment.
    // -------------------------------------------------------------------------
    logic [NJ-1:0] jtag_in;
    logic [NJ-1:0] sync_dly;
    logic          tck_lead;
    logic          upd_lead;

    assign jtag_in = {jtag_tdi, jtag_update, jtag_shift,
                      jtag_capture, jtag_sel, jtag_tck};

    for (genvar gi = 0; gi < NJ; gi++) begin : g_sync
        logic [SYNC_STAGES:0] chain_d, chain_q;

        always_comb begin
            chain_d = {chain_q[SYNC_STAGES-1:0], jtag_in[gi]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                chain_q <= '0;
            end else begin
                chain_q <= chain_d;
            end
        end

        assign sync_dly[gi] = chain_q[SYNC_STAGES];

        if (gi == J_TCK) begin : g_tck_lead
            assign tck_lead = chain_q[SYNC_STAGES-1];
        end
        if (gi == J_UPD) begin : g_upd_lead
            assign upd_lead = chain_q[SYNC_STAGES-1];
        end
    end

    logic sel_s, cap_s, shift_s, tdi_s;
    assign sel_s   = sync_dly[J_SEL];
    assign cap_s   = sync_dly[J_CAP];
    assign shift_s = sync_dly[J_SHIFT];
    assign tdi_s   = sync_dly[J_TDI];

    logic tck_rise_d, tck_rise_q;
    logic upd_rise_d, upd_rise_q;

    always_comb begin
        tck_rise_d = tck_lead & ~sync_dly[J_TCK];
        upd_rise_d = upd_lead & ~sync_dly[J_UPD];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_rise_q <= 1'b0;
            upd_rise_q <= 1'b0;
        end else begin
            tck_rise_q <= tck_rise_d;
            upd_rise_q <= upd_rise_d;
        end
    end

    // -------------------------------------------------------------------------
    // Command decode and channel write enables.
    // -------------------------------------------------------------------------
    logic [DR_LEN-1:0] sr_d, sr_q;
    cmd_t              cmd;
    logic [PWM_W-1:0]  wr_duty;
    logic              cmd_ok;
    logic [NUM_CH-1:0] wr_en;

    always_comb begin
        cmd      = '0;
        cmd.wr   = sr_q[WR_BIT];
        cmd.chan = MAX_CH_W'(sr_q[CHAN_LSB +: CH_W]);
        wr_duty  = sr_q[DUTY_LSB +: PWM_W];
        cmd_ok   = upd_rise_q && sel_s && cmd_valid(cmd, NUM_CH);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_wr_en
        assign wr_en[gi] = cmd_ok && (cmd.chan == MAX_CH_W'(gi));
    end

    // -------------------------------------------------------------------------
    // Readback: last written channel and a mux over the pending duties.
    // -------------------------------------------------------------------------
`ifdef JTAG_LED_PWM_READBACK_EN
    logic [PWM_W-1:0] pend_all [NUM_CH];
    logic [CH_W-1:0]  last_chan_d, last_chan_q;
    logic [PWM_W-1:0] rb_duty;

    always_comb begin
        last_chan_d = last_chan_q;
        if (cmd_ok) begin
            last_chan_d = cmd.chan[CH_W-1:0];
        end

        rb_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (last_chan_q == CH_W'(i)) begin
                rb_duty = pend_all[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_chan_q <= '0;
        end else begin
            last_chan_q <= last_chan_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Shift register and TDO. Capture takes priority over shift on the same
    // TCK edge; without readback a capture is simply a no-op edge.
    // -------------------------------------------------------------------------
    logic tdo_d, tdo_q;

    always_comb begin
        sr_d  = sr_q;
        tdo_d = sr_q[0];

        if (tck_rise_q && sel_s) begin
            if (cap_s) begin
`ifdef JTAG_LED_PWM_READBACK_EN
                sr_d = {1'b0, last_chan_q, rb_duty};
`endif
            end else if (shift_s) begin
                sr_d = {tdi_s, sr_q[DR_LEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            tdo_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            tdo_q <= tdo_d;
        end
    end

    assign jtag_tdo = tdo_q;

    // -------------------------------------------------------------------------
    // Shared PWM counter. cnt_wrap marks the first clk of each period.
    // -------------------------------------------------------------------------
    logic [PWM_W-1:0] cnt_d, cnt_q;
    logic             cnt_wrap;

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        cnt_wrap = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Channels.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        jtag_led_pwm_ch #(
            .PWM_W      (PWM_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[gi]),
            .wr_duty  (wr_duty),
            .cnt      (cnt_q),
            .cnt_wrap (cnt_wrap),
`ifdef JTAG_LED_PWM_READBACK_EN
            .pend_o   (pend_all[gi]),
`endif
            .led_o    (led[gi])
        );
    end

endmodule

// File: tb/tb_jtag_led_pwm.sv
// -----------------------------------------------------------------------------
// tb_jtag_led_pwm
//
// Drives two instances from one JTAG bus: a 4-channel build and a 3-channel
// build (so chan=3 is an out-of-range channel for the second one). A small
// model keeps per-channel duties, the last written channel and the word the
// data register should hold; TDO is compared on every frame and LED duty is
// measured as lit clks over two full PWM periods.
// -----------------------------------------------------------------------------
module tb_jtag_led_pwm;

    localparam int DR_LEN = 11;
    localparam int WIN    = 512;   // two PWM periods

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jtag_tck = 1'b0;
    logic jtag_sel = 1'b0;
    logic jtag_capture = 1'b0;
    logic jtag_shift = 1'b0;
    logic jtag_update = 1'b0;
    logic jtag_tdi = 1'b0;
    logic tdo4, tdo3;
    logic [3:0] led4;
    logic [2:0] led3;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int duty4 [4];
    int duty3 [3];
    int last4 = 0;
    int last3 = 0;
    logic [DR_LEN-1:0] dr4 = '0;
    logic [DR_LEN-1:0] dr3 = '0;

    always #5 clk = ~clk;

    jtag_led_pwm #(.NUM_CH(4), .PWM_W(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .rst(rst), .jtag_tck(jtag_tck), .jtag_sel(jtag_sel),
        .jtag_capture(jtag_capture), .jtag_shift(jtag_shift),
        .jtag_update(jtag_update), .jtag_tdi(jtag_tdi),
        .jtag_tdo(tdo4), .led(led4)
    );

    jtag_led_pwm #(.NUM_CH(3), .PWM_W(8), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut3 (
        .clk(clk), .rst(rst), .jtag_tck(jtag_tck), .jtag_sel(jtag_sel),
        .jtag_capture(jtag_capture), .jtag_shift(jtag_shift),
        .jtag_update(jtag_update), .jtag_tdi(jtag_tdi),
        .jtag_tdo(tdo3), .led(led3)
    );

    task automatic model_reset();
        for (int k = 0; k < 4; k++) duty4[k] = 0;
        for (int k = 0; k < 3; k++) duty3[k] = 0;
        last4 = 0;
        last3 = 0;
        dr4 = '0;
        dr3 = '0;
    endtask

    function automatic logic [DR_LEN-1:0] mk_word(input int wr, input int ch, input int duty);
        logic [DR_LEN-1:0] w;
        w = {1'(wr), 2'(ch), 8'(duty)};
        return w;
    endfunction

    // Shift a full frame LSB first, checking the bits that come out on TDO.
    task automatic shift_frame(input logic [DR_LEN-1:0] w);
        logic [DR_LEN-1:0] got4;
        logic [DR_LEN-1:0] got3;
        got4 = '0;
        got3 = '0;
        jtag_sel = 1'b1;
        jtag_shift = 1'b1;
        for (int i = 0; i < DR_LEN; i++) begin
            jtag_tdi = w[i];
            repeat (4) @(negedge clk);
            got4[i] = tdo4;
            got3[i] = tdo3;
            jtag_tck = 1'b1;
            repeat (4) @(negedge clk);
            jtag_tck = 1'b0;
        end
        repeat (4) @(negedge clk);
        jtag_shift = 1'b0;
        jtag_tdi = 1'b0;
        vectors++;
        if (got4 !== dr4) begin
            miscompares++;
            $display("FAIL tdo_4ch: got %h required %h", got4, dr4);
        end
        vectors++;
        if (got3 !== dr3) begin
            miscompares++;
            $display("FAIL tdo_3ch: got %h required %h", got3, dr3);
        end
        $display("frame in=%h tdo_4ch=%h tdo_3ch=%h", w, got4, got3);
        dr4 = w;
        dr3 = w;
    endtask

    task automatic pulse_update(input logic [DR_LEN-1:0] w);
        int ch;
        jtag_update = 1'b1;
        repeat (8) @(negedge clk);
        jtag_update = 1'b0;
        repeat (6) @(negedge clk);
        ch = int'(w[9:8]);
        if (w[10]) begin
            duty4[ch] = int'(w[7:0]);
            last4 = ch;
            if (ch < 3) begin
                duty3[ch] = int'(w[7:0]);
                last3 = ch;
            end
        end
    endtask

    task automatic write_frame(input logic [DR_LEN-1:0] w);
        shift_frame(w);
        pulse_update(w);
    endtask

    task automatic do_capture();
        jtag_sel = 1'b1;
        jtag_capture = 1'b1;
        repeat (2) @(negedge clk);
        jtag_tck = 1'b1;
        repeat (4) @(negedge clk);
        jtag_tck = 1'b0;
        repeat (2) @(negedge clk);
        jtag_capture = 1'b0;
        repeat (4) @(negedge clk);
`ifdef JTAG_LED_PWM_READBACK_EN
        dr4 = {1'b0, 2'(last4), 8'(duty4[last4])};
        dr3 = {1'b0, 2'(last3), 8'(duty3[last3])};
`endif
        $display("capture last_4ch=%0d last_3ch=%0d", last4, last3);
    endtask

    // Count lit clks per LED over two periods once act has settled.
    task automatic check_leds(input string tag);
        int lit4 [4];
        int lit3 [3];
        int exp_n;
        for (int k = 0; k < 4; k++) lit4[k] = 0;
        for (int k = 0; k < 3; k++) lit3[k] = 0;
        repeat (300) @(negedge clk);
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (led4[k] === 1'b0) lit4[k]++;
            for (int k = 0; k < 3; k++) if (led3[k] === 1'b0) lit3[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            exp_n = (duty4[k] == 255) ? WIN : 2 * duty4[k];
            vectors++;
            if (lit4[k] !== exp_n) begin
                miscompares++;
                $display("FAIL %s lit_4ch[%0d]: got %0d required %0d", tag, k, lit4[k], exp_n);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_n = (duty3[k] == 255) ? WIN : 2 * duty3[k];
            vectors++;
            if (lit3[k] !== exp_n) begin
                miscompares++;
                $display("FAIL %s lit_3ch[%0d]: got %0d required %0d", tag, k, lit3[k], exp_n);
            end
        end
        $display("%s lit_4ch=%0d,%0d,%0d,%0d lit_3ch=%0d,%0d,%0d", tag,
                 lit4[0], lit4[1], lit4[2], lit4[3], lit3[0], lit3[1], lit3[2]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        vectors++;
        if (led4 !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_led_4ch: got %b required 1111", led4);
        end
        vectors++;
        if (led3 !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_led_3ch: got %b required 111", led3);
        end
        vectors++;
        if (tdo4 !== 1'b0 || tdo3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tdo: got %b%b required 00", tdo4, tdo3);
        end
        vectors++;
        if (dut4.cnt_q !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d required 0", dut4.cnt_q);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset led_4ch=%b led_3ch=%b", led4, led3);
    endtask

    task automatic test_write_ch2();
        write_frame(mk_word(1, 2, 8'h40));
        check_leds("write_ch2");
    endtask

    task automatic test_boundary();
        write_frame(mk_word(1, 0, 8'h00));
        write_frame(mk_word(1, 1, 8'hFF));
        check_leds("boundary");
    endtask

    task automatic test_ignored();
        write_frame(mk_word(0, 1, 8'h80));
        write_frame(mk_word(1, 3, 8'h33));   // valid on 4ch, out of range on 3ch
        check_leds("ignored");
    endtask

    task automatic test_readback();
        write_frame(mk_word(1, 3, 8'hA5));
        do_capture();
        shift_frame(mk_word(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255))));
        // Plain frame without capture: TDO returns the previous frame.
        shift_frame(mk_word(0, 1, 8'h5A));
    endtask

    task automatic test_random();
        int wr, ch, d, r;
        for (int round = 0; round < 4; round++) begin
            for (int j = 0; j < 3; j++) begin
                wr = ($urandom_range(0, 3) != 0) ? 1 : 0;
                ch = int'($urandom_range(0, 3));
                r = int'($urandom_range(0, 5));
                d = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 254));
                write_frame(mk_word(wr, ch, d));
            end
            do_capture();
            shift_frame(mk_word(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255))));
            check_leds("random");
        end
    endtask

    task automatic test_reset_midshift();
        logic [DR_LEN-1:0] w;
        w = mk_word(1, 2, int'($urandom_range(1, 255)));
        jtag_sel = 1'b1;
        jtag_shift = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jtag_tdi = w[i];
            repeat (4) @(negedge clk);
            jtag_tck = 1'b1;
            repeat (4) @(negedge clk);
            jtag_tck = 1'b0;
        end
        rst = 1'b1;
        jtag_shift = 1'b0;
        jtag_tdi = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        vectors++;
        if (led4 !== 4'b1111 || tdo4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midshift_reset: led=%b tdo=%b required 1111/0", led4, tdo4);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset after 5 of %0d bits", DR_LEN);
        write_frame(mk_word(1, 0, 8'h10));
        check_leds("midshift");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_ch2();
        test_boundary();
        test_ignored();
        test_readback();
        test_random();
        test_reset_midshift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
